// File: rtl/neuron_mac_ctrl.sv
// neuron_mac_ctrl: sequences 16 pixel/weight reads, accumulates signed products onto a bias,
// applies optional ReLU and holds the result under a valid/ready handshake.
`default_nettype none

module neuron_mac_ctrl #(
    parameter int N_PIX = 16,
    parameter int ACC_W = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [15:0]             bias,
    input  logic                    relu_en,
    output logic [3:0]              mem_addr,
    input  logic [7:0]              pix_data,
    input  logic [7:0]              wgt_data,
    output logic                    busy,
    output logic signed [ACC_W-1:0] result,
    output logic                    result_valid,
    input  logic                    result_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam logic [3:0] c_LAST_ADDR = 4'(N_PIX - 1);

    state_t                  r_state;
    logic [3:0]              r_addr;
    logic                    r_rd_vld;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_relu;
    logic                    r_busy;
    logic signed [ACC_W-1:0] r_result;
    logic                    r_valid;

    logic signed [16:0]      w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_bias_ext;
    logic signed [ACC_W-1:0] w_sum;

    // Pixel is unsigned, so a zero MSB makes it a non-negative 9-bit signed operand.
    assign w_prod     = $signed({1'b0, pix_data}) * $signed(wgt_data);
    assign w_prod_ext = {{(ACC_W-17){w_prod[16]}}, w_prod};
    assign w_bias_ext = {{(ACC_W-16){bias[15]}}, bias};
    assign w_sum      = r_acc + w_prod_ext;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_addr   <= 4'd0;
            r_rd_vld <= 1'b0;
            r_acc    <= '0;
            r_relu   <= 1'b0;
            r_busy   <= 1'b0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_FETCH;
                        r_busy   <= 1'b1;
                        r_acc    <= w_bias_ext;
                        r_relu   <= relu_en;
                        r_addr   <= 4'd0;
                        r_rd_vld <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (abort) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_addr   <= 4'd0;
                        r_rd_vld <= 1'b0;
                    end else begin
                        // Read data lags the address by one cycle; the flag marks it usable.
                        r_rd_vld <= 1'b1;
                        if (r_rd_vld)
                            r_acc <= w_sum;
                        if (r_addr == c_LAST_ADDR)
                            r_state <= S_DRAIN;
                        else
                            r_addr <= r_addr + 4'd1;
                    end
                end
                S_DRAIN: begin
                    r_rd_vld <= 1'b0;
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_addr  <= 4'd0;
                    end else begin
                        r_result <= (r_relu && w_sum[ACC_W-1]) ? '0 : w_sum;
                        r_valid  <= 1'b1;
                        r_state  <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (result_ready) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_valid  <= 1'b0;
                    r_rd_vld <= 1'b0;
                    r_addr   <= 4'd0;
                end
            endcase
        end
    end

    assign mem_addr     = r_addr;
    assign busy         = r_busy;
    assign result       = r_result;
    assign result_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_neuron_mac_ctrl.sv
// tb_neuron_mac_ctrl: table-driven dot-product vectors plus hand-written handshake,
// abort and reset sequences against a registered-read memory model.
`default_nettype none

module tb_neuron_mac_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] bias;
    logic        relu_en;
    logic [3:0]  mem_addr;
    logic [7:0]  pix_data;
    logic [7:0]  wgt_data;
    logic        busy;
    logic signed [23:0] result;
    logic        result_valid;
    logic        result_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] pix_mem [16];
    logic [7:0] wgt_mem [16];
    logic [7:0] pix_a   [16];

    typedef struct {
        logic               set255;
        logic signed [7:0]  w;
        logic               alt;
        logic [15:0]        b;
        logic               relu;
        logic signed [23:0] exp;
    } vec_t;

    vec_t vt [8];

    neuron_mac_ctrl #(.N_PIX(16), .ACC_W(24)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .bias         (bias),
        .relu_en      (relu_en),
        .mem_addr     (mem_addr),
        .pix_data     (pix_data),
        .wgt_data     (wgt_data),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        pix_data <= pix_mem[mem_addr];
        wgt_data <= wgt_mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic load_mem(input logic set255, input logic signed [7:0] w, input logic alt);
        for (int i = 0; i < 16; i++) begin
            pix_mem[i] = set255 ? 8'd255 : pix_a[i];
            wgt_mem[i] = (alt && i[0]) ? 8'(-w) : w;
        end
    endtask

    // Called at a negedge; returns at a negedge with the FSM back in IDLE.
    task automatic run_op(input logic [15:0] b, input logic r, input logic signed [23:0] exp,
                          input int hold, input logic ab_with_start);
        logic addr_ok;
        bias = b; relu_en = r; start = 1'b1; abort = ab_with_start;
        result_ready = (hold == 0);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        addr_ok = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (mem_addr !== 4'(k) || busy !== 1'b1) addr_ok = 1'b0;
            if (k < 15) @(negedge clk);
        end
        chk("fetch_addr_seq", 24'(addr_ok), 24'd1);
        @(negedge clk);
        chk("drain_not_valid", 24'(result_valid), 24'd0);
        chk("drain_addr_hold", 24'(mem_addr), 24'd15);
        @(negedge clk);
        chk("valid_cycle18", 24'(result_valid), 24'd1);
        chk("result", result, exp);
        for (int h = 1; h <= hold; h++) begin
            start = (h == 2);
            abort = (h == 3);
            @(negedge clk);
            chk("hold_valid", 24'(result_valid), 24'd1);
            chk("hold_result", result, exp);
        end
        start = 1'b0; abort = 1'b0; result_ready = 1'b1;
        @(negedge clk);
        chk("post_hs_busy", 24'(busy), 24'd0);
        chk("post_hs_valid", 24'(result_valid), 24'd0);
        chk("post_hs_result", result, exp);
    endtask

    initial begin
        pix_a = '{8'd12, 8'd34, 8'd56, 8'd78, 8'd90, 8'd45, 8'd67, 8'd89,
                  8'd23, 8'd44, 8'd66, 8'd88, 8'd11, 8'd22, 8'd33, 8'd44};
        vt[0] = '{1'b0,  8'sd1,    1'b0, 16'd0,      1'b0, 24'sd802};
        vt[1] = '{1'b0, -8'sd1,    1'b0, 16'd100,    1'b0, -24'sd702};
        vt[2] = '{1'b0, -8'sd1,    1'b0, 16'd100,    1'b1, 24'sd0};
        vt[3] = '{1'b1, -8'sd128,  1'b0, 16'h8000,   1'b0, -24'sd555008};
        vt[4] = '{1'b1, -8'sd128,  1'b0, 16'h8000,   1'b1, 24'sd0};
        vt[5] = '{1'b0,  8'sd2,    1'b0, 16'hFC18,   1'b1, 24'sd604};
        vt[6] = '{1'b1,  8'sd127,  1'b0, 16'd32767,  1'b0, 24'sd550927};
        vt[7] = '{1'b0,  8'sd1,    1'b1, 16'd0,      1'b0, -24'sd86};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; bias = '0; relu_en = 1'b0;
        result_ready = 1'b1;
        load_mem(1'b0, 8'sd1, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_busy",  24'(busy), 24'd0);
        chk("rst_addr",  24'(mem_addr), 24'd0);
        chk("rst_result", result, 24'd0);
        chk("rst_valid", 24'(result_valid), 24'd0);

        // Start on the very first edge after reset release.
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            load_mem(vt[i].set255, vt[i].w, vt[i].alt);
            run_op(vt[i].b, vt[i].relu, vt[i].exp, 0, 1'b0);
        end

        // Backpressure: 5 cycles of ready low with an ignored start and abort inside.
        load_mem(1'b0, 8'sd1, 1'b0);
        run_op(16'd0, 1'b0, 24'sd802, 5, 1'b0);
        load_mem(1'b0, -8'sd1, 1'b0);
        run_op(16'd100, 1'b0, -24'sd702, 0, 1'b0);

        // Abort in cycle 8 of FETCH.
        load_mem(1'b0, 8'sd1, 1'b0);
        start = 1'b1; result_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_pre_addr", 24'(mem_addr), 24'd7);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy",   24'(busy), 24'd0);
        chk("abort_valid",  24'(result_valid), 24'd0);
        chk("abort_addr",   24'(mem_addr), 24'd0);
        chk("abort_result", result, -24'sd702);
        repeat (3) @(negedge clk);
        chk("abort_idle_busy", 24'(busy), 24'd0);
        // Start and abort together in IDLE: start wins.
        run_op(16'd0, 1'b0, 24'sd802, 0, 1'b1);

        // Reset during DRAIN.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        chk("pre_rst_drain_addr", 24'(mem_addr), 24'd15);
        rst_n = 1'b0;
        @(negedge clk);
        chk("drain_rst_busy",   24'(busy), 24'd0);
        chk("drain_rst_addr",   24'(mem_addr), 24'd0);
        chk("drain_rst_result", result, 24'd0);
        chk("drain_rst_valid",  24'(result_valid), 24'd0);
        rst_n = 1'b1;
        load_mem(1'b1, -8'sd128, 1'b0);
        run_op(16'h8000, 1'b0, -24'sd555008, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
